pipeline_exec_ctrl: RTL

Execution sequencer for the 5-stage MIPS pipeline. It generates the enable, stall and bubble strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It supports continuous run, single-step and pause from the debug unit, plus load-use stalls from the hazard unit. When a HALT instruction is decoded it drains all in-flight instructions through writeback, then parks in DONE.

---
 rtl/pipeline_exec_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipeline_exec_ctrl.sv
// rtl/pipeline_exec_ctrl.sv - execution sequencer for the 5-stage MIPS pipeline
module pipeline_exec_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_run,
    input  logic                 step_req,
    input  logic                 halt_req,
    input  logic                 halt_detected,
    input  logic                 load_use_stall,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 stage_en,
    output logic                 id_ex_bubble,
    output logic                 done,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   drain_cnt;
    logic            step_prev;
    logic            step_edge;

    assign state     = state_q;
    assign step_edge = step_req & ~step_prev;

    // Strobes are Mealy so a stall or HALT freezes the front end in the same cycle.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        stage_en     = 1'b0;
        id_ex_bubble = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_RUN, S_STEP: begin
                if (halt_detected) begin
                    stage_en = 1'b1;
                end else if (load_use_stall) begin
                    stage_en     = 1'b1;
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    stage_en = 1'b1;
                end
            end
            S_DRAIN: begin
                stage_en     = 1'b1;
                id_ex_bubble = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drain_cnt   <= '0;
            step_prev   <= 1'b0;
            cycle_count <= '0;
        end else begin
            step_prev <= step_req;
            if (stage_en && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_WIDTH'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (start_run) begin
                        state_q <= S_RUN;
                    end else if (step_edge) begin
                        state_q <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (halt_detected) begin
                        state_q   <= S_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end else if (halt_req) begin
                        state_q <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (halt_detected) begin
                        state_q   <= S_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                S_DONE: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
